bht_btb_predictor: RTL
======================

// Module: bht_btb_predictor
// PURPOSE
//  Direct-mapped branch history table + target buffer feeding the IF/ID stage register.
//  IF side: combinational lookup on fetch PC -> predicted direction/target + 2-bit state.
//  EX side: the 2-bit state and is_branch flag carried down the pipe return on the update port.
//  Sequential: saturating-counter update, allocation, mispredict flag and perf counters.
// PARAMETERS
//  PC_W     32  PC / target width in bits
//  IDX_W    4   index bits; table depth = 2**IDX_W; index = pc[IDX_W+1:2]
//  TAG_W    8   tag bits; tag = pc[IDX_W+TAG_W+1:IDX_W+2]
//  CNT_W    32  width of each perf counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  lk_pc          in   PC_W   fetch PC to look up (IF stage)
//  lk_hit         out  1      valid entry with matching tag
//  lk_taken       out  1      predicted taken (= lk_state[1])
//  lk_target      out  PC_W   entry target if lk_taken, else lk_pc+4
//  lk_state       out  2      state forwarded to the stage register's bht_state input
//  upd_en         in   1      EX-stage instruction valid, not squashed
//  upd_is_branch  in   1      carried is_branch flag
//  upd_pc         in   PC_W   PC of the resolving instruction
//  upd_state      in   2      carried bht_state for that instruction
//  upd_taken      in   1      actual outcome
//  upd_target     in   PC_W   actual taken target
//  mispredict     out  1      registered: direction mispredict seen last cycle
//  perf_branches  out  CNT_W  resolved branch count
//  perf_mispred   out  CNT_W  mispredict count
// BEHAVIOUR
//  - Lookup is purely combinational; a miss yields lk_hit=0, lk_state=2'b01, lk_taken=0.
//  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = state[1].
//  - Update fires when upd_en && upd_is_branch; otherwise the table is untouched.
//    The next state is computed from upd_state, not from the table:
//    taken -> min(upd_state+1, 3); not taken -> max(upd_state-1, 0).
//  - Write rules:
//    * tag hit -> write counter; target overwritten with upd_target only when upd_taken.
//    * tag miss + taken -> allocate: valid=1, tag, target, counter=2'b10; replaces any victim.
//    * tag miss + not taken -> no write.
//  - Writes land at the clock edge. A same-cycle lookup of the same index sees old contents (no bypass).
//  - mispredict <= update_fire && (upd_state[1] != upd_taken); one-cycle pulse, registered.
//  - perf_branches increments on every update fire; perf_mispred increments when the mispredict
//    condition holds. Both saturate at all-ones and never wrap.
//  - Reset (rst=1 at a clock edge):
//    * all valid bits 0, counters 2'b01, mispredict 0, perf counters 0;
//    * tag/target storage need not be cleared;
//    * an update presented during reset is dropped.
//  - Reset has priority over an update in the same cycle. Mid-operation reset loses all history.
// TESTING
//  1 reset, lk_pc=0x100 -> lk_hit=0, lk_state=01, lk_taken=0, lk_target=0x104; perf=0.
//  2 update pc=0x100 state=01 taken tgt=0x200 -> mispredict=1 next cycle; lookup 0x100 hit,
//    state=10, target=0x200.
//  3 four taken updates from state 11 at 0x100 -> state stays 11; perf_branches=4, perf_mispred=0.
//  4 not-taken update on miss pc=0x300 -> no allocation; lookup 0x300 still lk_hit=0.
//  5 alias: 0x100 allocated, then taken update pc=0x100+(1<<(IDX_W+2)) -> new tag replaces
//    the entry; 0x100 misses.
//  6 lookup/update same index in one cycle -> old value that cycle, new the next;
//    rst with upd_en=1 -> table cleared, counters 0.

Source files
------------

// File: rtl/bht_btb_predictor_if.sv
// Lookup/update/status bundle between the fetch/execute pipeline and the branch predictor.
// The pipeline side (master) drives lookup and update requests; the predictor (slave) answers.
interface bht_btb_predictor_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic [PC_W-1:0]  lk_pc;
  logic             lk_hit;
  logic             lk_taken;
  logic [PC_W-1:0]  lk_target;
  logic [1:0]       lk_state;
  logic             upd_en;
  logic             upd_is_branch;
  logic [PC_W-1:0]  upd_pc;
  logic [1:0]       upd_state;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             mispredict;
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_mispred;

  modport master (
    output lk_pc, upd_en, upd_is_branch, upd_pc, upd_state, upd_taken, upd_target,
    input  lk_hit, lk_taken, lk_target, lk_state, mispredict, perf_branches, perf_mispred
  );

  modport slave (
    input  lk_pc, upd_en, upd_is_branch, upd_pc, upd_state, upd_taken, upd_target,
    output lk_hit, lk_taken, lk_target, lk_state, mispredict, perf_branches, perf_mispred
  );
endinterface

// File: rtl/bht_btb_predictor.sv
// Direct-mapped 2-bit BHT plus BTB: combinational fetch lookup, EX-side counter update and
// allocation, registered mispredict pulse and saturating performance counters.
module bht_btb_predictor #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  bht_btb_predictor_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(3'd4);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

  logic             valid_r  [DEPTH];
  logic [1:0]       cnt_r    [DEPTH];
  logic [TAG_W-1:0] tag_r    [DEPTH];
  logic [PC_W-1:0]  target_r [DEPTH];
  logic             mispredict_r;
  logic [CNT_W-1:0] perf_branches_r;
  logic [CNT_W-1:0] perf_mispred_r;

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic [1:0]       lk_state_s;
  logic [PC_W-1:0]  lk_target_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_fire_s;
  logic             upd_hit_s;
  logic             cnt_we_s;
  logic [1:0]       cnt_wdata_s;
  logic             meta_we_s;
  logic             mispred_s;
  logic             unused_s;

  function automatic logic [1:0] sat_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (state == 2'b11) ? 2'b11 : state + 2'b01;
    end else begin
      nxt = (state == 2'b00) ? 2'b00 : state - 2'b01;
    end
    return nxt;
  endfunction

  assign lk_idx_s  = bus.lk_pc[IDX_W+1:2];
  assign lk_tag_s  = bus.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx_s = bus.upd_pc[IDX_W+1:2];
  assign upd_tag_s = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_s  = ^{bus.lk_pc[1:0], bus.lk_pc[PC_W-1:IDX_W+TAG_W+2],
                       bus.upd_pc[1:0], bus.upd_pc[PC_W-1:IDX_W+TAG_W+2]};

  // Fetch-side lookup; a miss reports weak-not-taken and falls through to pc+4.
  always_comb begin
    lk_hit_s    = 1'b0;
    lk_state_s  = 2'b01;
    lk_target_s = bus.lk_pc + PC_STEP;
    if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
      lk_hit_s   = 1'b1;
      lk_state_s = cnt_r[lk_idx_s];
    end else begin
      lk_hit_s   = 1'b0;
      lk_state_s = 2'b01;
    end
    if (lk_state_s[1]) begin
      lk_target_s = target_r[lk_idx_s];
    end else begin
      lk_target_s = bus.lk_pc + PC_STEP;
    end
  end

  // Update decode: the new counter derives from the carried state, not the table copy.
  always_comb begin
    upd_fire_s  = bus.upd_en && bus.upd_is_branch;
    upd_hit_s   = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    cnt_we_s    = 1'b0;
    cnt_wdata_s = 2'b10;
    if (upd_fire_s && upd_hit_s) begin
      cnt_we_s    = 1'b1;
      cnt_wdata_s = sat_next(bus.upd_state, bus.upd_taken);
    end else if (upd_fire_s && bus.upd_taken) begin
      cnt_we_s    = 1'b1;
      cnt_wdata_s = 2'b10;
    end else begin
      cnt_we_s    = 1'b0;
      cnt_wdata_s = 2'b10;
    end
    meta_we_s = upd_fire_s && bus.upd_taken;
    mispred_s = upd_fire_s && (bus.upd_state[1] != bus.upd_taken);
  end

  // Valid bits and counters; reset wins over a concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        cnt_r[i]   <= 2'b01;
      end
    end else if (cnt_we_s) begin
      valid_r[upd_idx_s] <= 1'b1;
      cnt_r[upd_idx_s]   <= cnt_wdata_s;
    end else begin
      valid_r[upd_idx_s] <= valid_r[upd_idx_s];
    end
  end

  // Tag/target storage is left uninitialised; valid bits guard it.
  always_ff @(posedge clk) begin
    if (!rst && meta_we_s) begin
      tag_r[upd_idx_s]    <= upd_tag_s;
      target_r[upd_idx_s] <= bus.upd_target;
    end
  end

  // Mispredict pulse and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_r    <= 1'b0;
      perf_branches_r <= {CNT_W{1'b0}};
      perf_mispred_r  <= {CNT_W{1'b0}};
    end else begin
      mispredict_r <= mispred_s;
      if (upd_fire_s && (perf_branches_r != CNT_FULL)) begin
        perf_branches_r <= perf_branches_r + CNT_ONE;
      end else begin
        perf_branches_r <= perf_branches_r;
      end
      if (mispred_s && (perf_mispred_r != CNT_FULL)) begin
        perf_mispred_r <= perf_mispred_r + CNT_ONE;
      end else begin
        perf_mispred_r <= perf_mispred_r;
      end
    end
  end

  assign bus.lk_hit        = lk_hit_s;
  assign bus.lk_state      = lk_state_s;
  assign bus.lk_taken      = lk_state_s[1];
  assign bus.lk_target     = lk_target_s;
  assign bus.mispredict    = mispredict_r;
  assign bus.perf_branches = perf_branches_r;
  assign bus.perf_mispred  = perf_mispred_r;
endmodule
